// File: rtl/pulse_xy_decoder.sv
// Recovers X/Y sample values from pulse-width-encoded streams by counting
// synchronized high cycles over fixed windows aligned to a Pulse_X rising edge.
module pulse_xy_decoder #(
   parameter int unsigned PERIOD_CYCLES = 256,
   parameter int unsigned CNT_W         = 9,
   parameter int unsigned SYNC_TIMEOUT  = 1024
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             Enable,
   input  logic             Pulse_X,
   input  logic             Pulse_Y,
   output logic [CNT_W-1:0] X_Value,
   output logic [CNT_W-1:0] Y_Value,
   output logic             Sample_Valid,
   output logic             Locked,
   output logic             Stuck_X,
   output logic             Stuck_Y
);

   localparam int unsigned WIN_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int unsigned TMO_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PERIOD_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SYNC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(PERIOD_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ALIGN   = 2'd1,
      S_MEASURE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic             px_m, px_s, px_d, py_m, py_s;
   logic [TMO_W-1:0] tmo_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] acc_x, acc_y;
   logic             aligned;

   logic             x_rise_c;
   logic             acc_en_c;
   logic             strobe_c;
   logic             tmo_en_c;
   logic             start_aligned_c;
   logic             start_unaligned_c;
   logic [CNT_W-1:0] sum_x_c, sum_y_c;

   // Two-flop synchronizers plus one delay stage for X edge detection
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         px_m <= 1'b0;
         px_s <= 1'b0;
         px_d <= 1'b0;
         py_m <= 1'b0;
         py_s <= 1'b0;
      end else begin
         px_m <= Pulse_X;
         px_s <= px_m;
         px_d <= px_s;
         py_m <= Pulse_Y;
         py_s <= py_m;
      end
   end

   assign x_rise_c = px_s & ~px_d;
   assign sum_x_c  = acc_x + CNT_W'(px_s);
   assign sum_y_c  = acc_y + CNT_W'(py_s);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n           = state;
      acc_en_c          = 1'b0;
      strobe_c          = 1'b0;
      tmo_en_c          = 1'b0;
      start_aligned_c   = 1'b0;
      start_unaligned_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (Enable) state_n = S_ALIGN;
         end
         S_ALIGN: begin
            if (!Enable) begin
               state_n = S_IDLE;
            end else if (x_rise_c) begin
               // the edge cycle itself is window cycle 0
               state_n         = S_MEASURE;
               start_aligned_c = 1'b1;
               acc_en_c        = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               state_n           = S_MEASURE;
               start_unaligned_c = 1'b1;
            end else begin
               tmo_en_c = 1'b1;
            end
         end
         S_MEASURE: begin
            acc_en_c = 1'b1;
            // a window completing as Enable drops still reports
            if (win_cnt == WIN_LAST) strobe_c = 1'b1;
            if (!Enable) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Window counters and accumulators; cleared whenever not accumulating
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         win_cnt <= '0;
         acc_x   <= '0;
         acc_y   <= '0;
         aligned <= 1'b0;
      end else begin
         tmo_cnt <= tmo_en_c ? tmo_cnt + TMO_W'(1) : '0;
         if (acc_en_c && !strobe_c && state_n == S_MEASURE) begin
            win_cnt <= win_cnt + WIN_W'(1);
            acc_x   <= sum_x_c;
            acc_y   <= sum_y_c;
         end else begin
            win_cnt <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
         end
         if (start_aligned_c)                                aligned <= 1'b1;
         else if (start_unaligned_c || state_n == S_IDLE)    aligned <= 1'b0;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         X_Value      <= '0;
         Y_Value      <= '0;
         Sample_Valid <= 1'b0;
         Locked       <= 1'b0;
         Stuck_X      <= 1'b0;
         Stuck_Y      <= 1'b0;
      end else begin
         Sample_Valid <= strobe_c;
         if (strobe_c) begin
            X_Value <= sum_x_c;
            Y_Value <= sum_y_c;
            Stuck_X <= (sum_x_c == '0) || (sum_x_c == FULL);
            Stuck_Y <= (sum_y_c == '0) || (sum_y_c == FULL);
         end
         if (!Enable)                  Locked <= 1'b0;
         else if (strobe_c && aligned) Locked <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pulse_xy_decoder.sv
// Directed bench for pulse_xy_decoder: periodic decode, stuck inputs, alignment
// timeout, enable drop/re-enable and asynchronous reset mid-window.
module tb_pulse_xy_decoder;

   localparam int unsigned P = 256;
   localparam int unsigned W = 9;

   logic         sysclk = 1'b0;
   logic         rst_n = 1'b0;
   logic         Enable = 1'b0;
   logic         Pulse_X = 1'b0;
   logic         Pulse_Y = 1'b0;
   logic [W-1:0] X_Value, Y_Value;
   logic         Sample_Valid, Locked, Stuck_X, Stuck_Y;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cyc = 0;
   int unsigned ph = 0;
   int unsigned mode = 0;
   int unsigned sv_cnt = 0;
   int unsigned first_rise = 0;
   bit          armed = 1'b0;
   logic        prev_x = 1'b0;

   always #5 sysclk = ~sysclk;

   pulse_xy_decoder #(.PERIOD_CYCLES(P), .CNT_W(W), .SYNC_TIMEOUT(1024)) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .Enable      (Enable),
      .Pulse_X     (Pulse_X),
      .Pulse_Y     (Pulse_Y),
      .X_Value     (X_Value),
      .Y_Value     (Y_Value),
      .Sample_Valid(Sample_Valid),
      .Locked      (Locked),
      .Stuck_X     (Stuck_X),
      .Stuck_Y     (Stuck_Y)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One clock: sample outputs just after the edge, then drive the next pin values
   task automatic tick();
      @(posedge sysclk);
      #1;
      cyc++;
      if (Sample_Valid) sv_cnt++;
      case (mode)
         1: begin
            Pulse_X = (ph < 64);
            Pulse_Y = (ph < 192);
            ph = (ph + 1) % P;
         end
         2: begin
            Pulse_X = 1'b1;
            Pulse_Y = 1'b0;
         end
         3: begin
            Pulse_X = 1'b0;
            Pulse_Y = ph[0];
            ph++;
         end
         default: begin
            Pulse_X = 1'b0;
            Pulse_Y = 1'b0;
         end
      endcase
      if (Pulse_X && !prev_x && armed) begin
         first_rise = cyc;
         armed = 1'b0;
      end
      prev_x = Pulse_X;
   endtask

   task automatic wait_sv(input int unsigned max_ticks, output int unsigned at);
      at = 0;
      for (int i = 0; i < max_ticks; i++) begin
         tick();
         if (Sample_Valid) begin
            at = cyc;
            return;
         end
      end
      check("sv_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned at, s1, n0, e;

      // Reset state
      repeat (3) tick();
      check("reset_values", {X_Value, Y_Value}, 0);
      check("reset_flags", {Sample_Valid, Locked, Stuck_X, Stuck_Y}, 0);

      // Periodic X 64/256, Y 192/256, aligned
      rst_n = 1'b1;
      Enable = 1'b1;
      repeat (3) tick();
      ph = 0;
      mode = 1;
      armed = 1'b1;
      wait_sv(600, at);
      check("t1_latency", at - first_rise, 258);
      check("t1_x", X_Value, 64);
      check("t1_y", Y_Value, 192);
      check("t1_locked", Locked, 1);
      check("t1_stuck", {Stuck_X, Stuck_Y}, 0);
      s1 = at;
      tick();
      check("t1_strobe_width", Sample_Valid, 0);
      wait_sv(300, at);
      check("t1_period", at - s1, 256);
      check("t1_x2", X_Value, 64);

      // Enable dropped at window cycle ~100, then re-enabled
      repeat (100) tick();
      n0 = sv_cnt;
      Enable = 1'b0;
      repeat (300) tick();
      check("t2_no_strobe", sv_cnt - n0, 0);
      check("t2_x_hold", X_Value, 64);
      check("t2_y_hold", Y_Value, 192);
      check("t2_unlocked", Locked, 0);
      while (ph != 128) tick();
      Enable = 1'b1;
      armed = 1'b1;
      wait_sv(600, at);
      check("t2_realign_latency", at - first_rise, 258);
      check("t2_relocked", Locked, 1);

      // Asynchronous reset between clock edges mid-window
      while (ph != 150) tick();
      #3 rst_n = 1'b0;
      #1;
      check("t5_reset_values", {X_Value, Y_Value}, 0);
      check("t5_reset_flags", {Sample_Valid, Locked, Stuck_X, Stuck_Y}, 0);
      repeat (10) tick();
      rst_n = 1'b1;
      armed = 1'b1;
      wait_sv(600, at);
      check("t5_latency", at - first_rise, 258);
      check("t5_x", X_Value, 64);
      check("t5_y", Y_Value, 192);
      check("t5_locked", Locked, 1);

      // X stuck high after one rising edge, Y stuck low
      tick();
      Enable = 1'b0;
      mode = 0;
      repeat (5) tick();
      Enable = 1'b1;
      repeat (5) tick();
      mode = 2;
      armed = 1'b1;
      wait_sv(600, at);
      check("t3_latency", at - first_rise, 258);
      check("t3_x_full", X_Value, 256);
      check("t3_y_zero", Y_Value, 0);
      check("t3_stuck", {Stuck_X, Stuck_Y}, 3);
      check("t3_locked", Locked, 1);
      s1 = at;
      // Enable drops during the last sample cycle: the strobe still fires
      while (cyc != s1 + 255) tick();
      Enable = 1'b0;
      tick();
      check("t3_strobe_on_disable", Sample_Valid, 1);
      check("t3_x_on_disable", X_Value, 256);
      tick();
      check("t3_unlocked", Locked, 0);

      // No X edge: timeout after 1024 ALIGN cycles, Y at 50% duty
      mode = 3;
      repeat (5) tick();
      e = cyc;
      Enable = 1'b1;
      wait_sv(1400, at);
      check("t4_timeout_latency", at - e, 1281);
      check("t4_x", X_Value, 0);
      check("t4_y", Y_Value, 128);
      check("t4_unlocked", Locked, 0);
      check("t4_stuck", {Stuck_X, Stuck_Y}, 2);
      wait_sv(300, at);
      check("t4_still_unlocked", Locked, 0);
      check("t4_y2", Y_Value, 128);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
